mix_columns_serial: RTL and testbench

Column-serial round-mix stage that sits between the SubBytes/ShiftRows stage and the next round's state register. It takes a full 128-bit AES state and a round key, then runs one `mixColumns_col` instance and one `invMixColumns_col` instance over the four columns, one column per cycle. AddRoundKey is folded in at the position each direction requires. Valid/ready handshakes on both sides let the round controller stall or feed it freely.

---
 rtl/mix_columns_serial_if.sv | 26 ++
 rtl/mix_columns_serial.sv | 155 +++++++++++++++
 tb/tb_mix_columns_serial.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mix_columns_serial_if.sv
// Handshake and data bundle for the column-serial round-mix stage.
`default_nettype none

interface mix_columns_serial_if;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [127:0] state_i;
  logic [127:0] key_i;
  logic         inv_i;
  logic         bypass_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [127:0] data_o;

  modport slave (
    input  in_valid_i, state_i, key_i, inv_i, bypass_i, out_ready_i,
    output in_ready_o, out_valid_o, data_o
  );

  modport master (
    output in_valid_i, state_i, key_i, inv_i, bypass_i, out_ready_i,
    input  in_ready_o, out_valid_o, data_o
  );
endinterface

`default_nettype wire

// File: rtl/mix_columns_serial.sv
// ============================================================================
// Module   : mix_columns_serial
// Purpose  : AES round mix, one column per cycle, with AddRoundKey folded in.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mixColumns_col (
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] w_a0, w_a1, w_a2, w_a3;
  assign {w_a0, w_a1, w_a2, w_a3} = col_i;

  assign col_o[31:24] = xt(w_a0) ^ xt(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
  assign col_o[23:16] = w_a0 ^ xt(w_a1) ^ xt(w_a2) ^ w_a2 ^ w_a3;
  assign col_o[15:8]  = w_a0 ^ w_a1 ^ xt(w_a2) ^ xt(w_a3) ^ w_a3;
  assign col_o[7:0]   = xt(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xt(w_a3);
endmodule

module invMixColumns_col (
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Per-byte multiples by 9, 11, 13 and 14 built from 2x, 4x and 8x.
  logic [7:0] w_m9[4], w_mb[4], w_md[4], w_me[4];
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      logic [7:0] a, x2, x4, x8;
      a     = col_i[31-8*i -: 8];
      x2    = xt(a);
      x4    = xt(x2);
      x8    = xt(x4);
      w_m9[i] = x8 ^ a;
      w_mb[i] = x8 ^ x2 ^ a;
      w_md[i] = x8 ^ x4 ^ a;
      w_me[i] = x8 ^ x4 ^ x2;
    end
  end

  assign col_o[31:24] = w_me[0] ^ w_mb[1] ^ w_md[2] ^ w_m9[3];
  assign col_o[23:16] = w_m9[0] ^ w_me[1] ^ w_mb[2] ^ w_md[3];
  assign col_o[15:8]  = w_md[0] ^ w_m9[1] ^ w_me[2] ^ w_mb[3];
  assign col_o[7:0]   = w_mb[0] ^ w_md[1] ^ w_m9[2] ^ w_me[3];
endmodule

module mix_columns_serial (
  input  logic                 clk_i,
  input  logic                 rst_i,
  mix_columns_serial_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e       fsm_q, fsm_d;
  logic [1:0]   col_q, col_d;
  logic [127:0] state_q, state_d;
  logic [127:0] key_q, key_d;
  logic         inv_q, inv_d;
  logic         byp_q, byp_d;
  logic [127:0] data_q, data_d;

  logic [31:0]  w_scol, w_kcol, w_fwd, w_inv, w_res;

  always_comb begin
    w_scol = state_q[127:96];
    w_kcol = key_q[127:96];
    case (col_q)
      2'd1: begin w_scol = state_q[95:64]; w_kcol = key_q[95:64]; end
      2'd2: begin w_scol = state_q[63:32]; w_kcol = key_q[63:32]; end
      2'd3: begin w_scol = state_q[31:0];  w_kcol = key_q[31:0];  end
      default: ;
    endcase
  end

  mixColumns_col    u_fwd (.col_i(w_scol),          .col_o(w_fwd));
  invMixColumns_col u_inv (.col_i(w_scol ^ w_kcol), .col_o(w_inv));

  // Encrypt adds the key after mixing; decrypt adds it before.
  assign w_res = byp_q ? (w_scol ^ w_kcol) :
                 inv_q ? w_inv : (w_fwd ^ w_kcol);

  always_comb begin
    fsm_d   = fsm_q;
    col_d   = col_q;
    state_d = state_q;
    key_d   = key_q;
    inv_d   = inv_q;
    byp_d   = byp_q;
    data_d  = data_q;
    case (fsm_q)
      IDLE: begin
        if (bus.in_valid_i) begin
          state_d = bus.state_i;
          key_d   = bus.key_i;
          inv_d   = bus.inv_i;
          byp_d   = bus.bypass_i;
          col_d   = 2'd0;
          fsm_d   = RUN;
        end
      end
      RUN: begin
        case (col_q)
          2'd0:    data_d[127:96] = w_res;
          2'd1:    data_d[95:64]  = w_res;
          2'd2:    data_d[63:32]  = w_res;
          default: data_d[31:0]   = w_res;
        endcase
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) fsm_d = DONE;
      end
      DONE: begin
        if (bus.out_ready_i) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q   <= IDLE;
      col_q   <= 2'd0;
      state_q <= '0;
      key_q   <= '0;
      inv_q   <= 1'b0;
      byp_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      fsm_q   <= fsm_d;
      col_q   <= col_d;
      state_q <= state_d;
      key_q   <= key_d;
      inv_q   <= inv_d;
      byp_q   <= byp_d;
      data_q  <= data_d;
    end
  end

  assign bus.in_ready_o  = (fsm_q == IDLE);
  assign bus.out_valid_o = (fsm_q == DONE);
  assign bus.data_o      = data_q;
endmodule

`default_nettype wire

// File: tb/tb_mix_columns_serial.sv
// ============================================================================
// Module   : tb_mix_columns_serial
// Purpose  : Vector table, corner sequences and random blocks vs. a GF model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mix_columns_serial;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mix_columns_serial_if bus ();
  mix_columns_serial u_dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [127:0] st;
    logic [127:0] key;
    logic         inv;
    logic         byp;
    logic [127:0] exp;
  } vec_t;
  vec_t vecs[5];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_model(input logic [127:0] s, input logic [127:0] k,
                                             input logic inv, input logic byp);
    logic [7:0]   a[16];
    logic [7:0]   cf[4];
    logic [7:0]   acc;
    logic [127:0] x, res;
    if (byp) return s ^ k;
    x = inv ? (s ^ k) : s;
    if (inv) begin cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09; end
    else     begin cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01; end
    for (int i = 0; i < 16; i++) a[i] = x[127-8*i -: 8];
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc ^= gmul(cf[(j - r + 4) % 4], a[4*c + j]);
        res[127-8*(4*c+r) -: 8] = acc;
      end
    return inv ? res : (res ^ k);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Presents a block, waits for the accept edge, then scrambles the inputs.
  task automatic accept(input logic [127:0] s, input logic [127:0] k,
                        input logic inv, input logic byp);
    int guard = 0;
    @(negedge clk);
    bus.state_i = s; bus.key_i = k; bus.inv_i = inv; bus.bypass_i = byp;
    bus.in_valid_i = 1'b1;
    while (!bus.in_ready_o && guard < 20) begin @(negedge clk); guard++; end
    if (guard >= 20) chk("accept_timeout", 128'(bus.in_ready_o), 128'd1);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    bus.state_i = {$urandom, $urandom, $urandom, $urandom};
    bus.key_i   = {$urandom, $urandom, $urandom, $urandom};
    bus.inv_i   = ~inv;
    bus.bypass_i = ~byp;
  endtask

  // Called one step after the accept edge (cycle 1); returns the cycle of out_valid.
  task automatic wait_done(output int n);
    n = 1;
    while (!bus.out_valid_o && n < 20) begin @(posedge clk); #1; n++; end
  endtask

  task automatic handshake();
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.out_ready_i = 1'b0;
  endtask

  initial begin
    logic [127:0] s, k, held, expv;
    logic         iv, bp;
    int           lat;

    vecs[0] = '{128'hdb135345_f20a225c_01010101_c6c6c6c6, 128'h0, 1'b0, 1'b0,
                128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};
    vecs[1] = '{128'hdb135345_f20a225c_01010101_c6c6c6c6, {128{1'b1}}, 1'b0, 1'b0,
                128'h71b25e43_6023a762_fefefefe_39393939};
    vecs[2] = '{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 128'h0, 1'b1, 1'b0,
                128'hdb135345_f20a225c_01010101_c6c6c6c6};
    vecs[3] = '{128'h71b25e43_6023a762_fefefefe_39393939, {128{1'b1}}, 1'b1, 1'b0,
                128'hdb135345_f20a225c_01010101_c6c6c6c6};
    vecs[4] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                1'b1, 1'b1, 128'h00102030405060708090a0b0c0d0e0f0};

    bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b0;
    bus.state_i = '0; bus.key_i = '0; bus.inv_i = 1'b0; bus.bypass_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_out_valid", 128'(bus.out_valid_o), 128'd0);
    chk("reset_in_ready",  128'(bus.in_ready_o),  128'd1);
    chk("reset_data",      bus.data_o,            128'd0);

    for (int i = 0; i < 5; i++) begin
      accept(vecs[i].st, vecs[i].key, vecs[i].inv, vecs[i].byp);
      wait_done(lat);
      chk($sformatf("vec%0d_data", i), bus.data_o, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), 128'(lat), 128'd5);
      handshake();
      chk($sformatf("vec%0d_release", i), 128'(bus.out_valid_o), 128'd0);
    end

    // Backpressure: three stalled cycles in DONE.
    s = 128'h0123456789abcdef_fedcba9876543210;
    k = 128'h0f1e2d3c4b5a6978_8796a5b4c3d2e1f0;
    accept(s, k, 1'b0, 1'b0);
    wait_done(lat);
    held = bus.data_o;
    chk("bp_data", held, ref_model(s, k, 1'b0, 1'b0));
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold_data%0d", c),  bus.data_o, held);
      chk($sformatf("bp_hold_valid%0d", c), 128'(bus.out_valid_o), 128'd1);
      chk($sformatf("bp_in_ready%0d", c),   128'(bus.in_ready_o),  128'd0);
    end

    // Queued second block: accepted one cycle after the output handshake.
    s = {$urandom, $urandom, $urandom, $urandom};
    k = {$urandom, $urandom, $urandom, $urandom};
    bus.state_i = s; bus.key_i = k; bus.inv_i = 1'b1; bus.bypass_i = 1'b0;
    bus.in_valid_i = 1'b1;
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.out_ready_i = 1'b0;
    chk("queue_idle_ready", 128'(bus.in_ready_o),  128'd1);
    chk("queue_idle_valid", 128'(bus.out_valid_o), 128'd0);
    chk("queue_idle_data",  bus.data_o, held);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    chk("queue_accepted", 128'(bus.in_ready_o), 128'd0);
    wait_done(lat);
    chk("queue_data",    bus.data_o, ref_model(s, k, 1'b1, 1'b0));
    chk("queue_latency", 128'(lat), 128'd5);
    handshake();

    // Reset in cycle 2 of RUN.
    accept(vecs[0].st, vecs[0].key, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_valid", 128'(bus.out_valid_o), 128'd0);
    chk("rst_mid_ready", 128'(bus.in_ready_o),  128'd1);
    chk("rst_mid_data",  bus.data_o, 128'd0);
    accept(vecs[1].st, vecs[1].key, 1'b0, 1'b0);
    wait_done(lat);
    chk("rst_fresh_data",    bus.data_o, vecs[1].exp);
    chk("rst_fresh_latency", 128'(lat), 128'd5);
    handshake();

    // Random blocks with random modes and stalls.
    for (int t = 0; t < 30; t++) begin
      s  = {$urandom, $urandom, $urandom, $urandom};
      k  = {$urandom, $urandom, $urandom, $urandom};
      iv = 1'($urandom_range(0, 1));
      bp = ($urandom_range(0, 3) == 0);
      expv = ref_model(s, k, iv, bp);
      accept(s, k, iv, bp);
      wait_done(lat);
      chk($sformatf("rnd%0d_data", t), bus.data_o, expv);
      chk($sformatf("rnd%0d_latency", t), 128'(lat), 128'd5);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      chk($sformatf("rnd%0d_stall_data", t), bus.data_o, expv);
      handshake();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
